// File: rtl/led_nios_cpu_oci_trace_packer.sv
// Packs SLOTS narrow trace slots into one wide word and queues words in a small FIFO.
// On test_ending: flush partial word, drain FIFO, then raise sticky test_has_ended.
module led_nios_cpu_oci_trace_packer #(
    parameter int SLOT_W     = 10,
    parameter int SLOTS      = 3,
    parameter int CNT_W      = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int W         = SLOT_W * SLOTS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slot_valid,
    input  logic [SLOT_W-1:0] slot_data,
    output logic             in_ready,
    input  logic             test_ending,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] out_count,
    output logic [W-1:0]     dct_buffer,
    output logic [CNT_W-1:0] dct_count,
    output logic             test_has_ended,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN, ENDED} state_t;
    state_t state, state_nxt;

    logic [W-1:0]     mem_data [FIFO_DEPTH];
    logic [CNT_W-1:0] mem_cnt  [FIFO_DEPTH];
    logic [PW:0]      wptr, rptr;

    logic             accept, word_done, empty, full, pop, push, push_ok, drop;
    logic [W-1:0]     push_data;
    logic [CNT_W-1:0] push_cnt;

    // Extra pointer bit distinguishes full from empty when the low bits match.
    assign empty     = (wptr == rptr);
    assign full      = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem_data[rptr[PW-1:0]];
    assign out_count = empty ? '0 : mem_cnt[rptr[PW-1:0]];
    assign pop       = out_valid && out_ready;

    assign in_ready       = (state == RUN);
    assign test_has_ended = (state == ENDED);
    assign accept         = slot_valid && in_ready;
    assign word_done      = accept && (dct_count == CNT_W'(SLOTS - 1));

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        push_cnt  = '0;
        state_nxt = state;
        case (state)
            RUN: begin
                if (word_done) begin
                    push      = 1'b1;
                    push_data = {dct_buffer[W-SLOT_W-1:0], slot_data};
                    push_cnt  = CNT_W'(SLOTS);
                end
                if (test_ending) state_nxt = FLUSH;
            end
            FLUSH: begin
                // Partial word goes out as-is; unused upper slots are already zero.
                if (dct_count != '0) begin
                    push      = 1'b1;
                    push_data = dct_buffer;
                    push_cnt  = dct_count;
                end
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (empty) state_nxt = ENDED;
            end
            default: state_nxt = ENDED;
        endcase
    end

    assign push_ok = push && (!full || pop);
    assign drop    = push && !push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wptr[PW-1:0]] <= push_data;
            mem_cnt[wptr[PW-1:0]]  <= push_cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            wptr       <= '0;
            rptr       <= '0;
            dct_buffer <= '0;
            dct_count  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state <= state_nxt;
            if (push_ok) wptr <= wptr + (PW+1)'(1);
            if (pop)     rptr <= rptr + (PW+1)'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
            if (state == FLUSH || word_done) begin
                dct_buffer <= '0;
                dct_count  <= '0;
            end else if (accept) begin
                dct_buffer <= {dct_buffer[W-SLOT_W-1:0], slot_data};
                dct_count  <= dct_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_led_nios_cpu_oci_trace_packer.sv
// Directed bench for the trace packer: packing, flush/drain/end, overflow, reset mid-drain.
module tb_led_nios_cpu_oci_trace_packer;
    logic        clk = 1'b0;
    logic        reset;
    logic        slot_valid;
    logic [9:0]  slot_data;
    logic        in_ready;
    logic        test_ending;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_has_ended;
    logic        overflow;
    logic [3:0]  drop_count;

    int vectors = 0;
    int errors  = 0;

    led_nios_cpu_oci_trace_packer dut (
        .clk(clk), .reset(reset), .slot_valid(slot_valid), .slot_data(slot_data),
        .in_ready(in_ready), .test_ending(test_ending), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_has_ended(test_has_ended),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] d);
        slot_valid = 1'b1;
        slot_data  = d;
        step();
        slot_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        slot_valid  = 1'b0;
        test_ending = 1'b0;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] word3(input int a, input int b, input int c);
        return (32'(a) << 20) | (32'(b) << 10) | 32'(c);
    endfunction

    initial begin
        reset = 1'b1; slot_valid = 1'b0; slot_data = '0; test_ending = 1'b0; out_ready = 1'b1;
        step();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_dct_buffer", 32'(dct_buffer), 0);
        check("rst_dct_count", 32'(dct_count), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        check("rst_ended", 32'(test_has_ended), 0);
        reset = 1'b0;

        // Basic packing: newest slot lands in the LSBs.
        send(10'h001); send(10'h002); send(10'h003);
        check("pack_valid", 32'(out_valid), 1);
        check("pack_data", 32'(out_data), 32'h0010_0803);
        check("pack_count", 32'(out_count), 3);
        check("pack_dct_count", 32'(dct_count), 0);
        step();
        check("pack_popped", 32'(out_valid), 0);

        // Partial word flushed on test_ending.
        send(10'h3FF); send(10'h155);
        check("part_buffer", 32'(dct_buffer), 32'h000F_FD55);
        check("part_count", 32'(dct_count), 2);
        test_ending = 1'b1; step(); test_ending = 1'b0;
        check("flush_in_ready", 32'(in_ready), 0);
        check("flush_not_ended", 32'(test_has_ended), 0);
        step();
        check("flush_valid", 32'(out_valid), 1);
        check("flush_data", 32'(out_data), 32'h000F_FD55);
        check("flush_count", 32'(out_count), 2);
        check("flush_dct_clear", 32'(dct_count), 0);
        check("drain_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 10 && !test_has_ended; i++) step();
        check("ended", 32'(test_has_ended), 1);
        check("ended_empty", 32'(out_valid), 0);
        send(10'h2AA);
        test_ending = 1'b1; step(); test_ending = 1'b0;
        check("ended_ignores_slot", 32'(dct_count), 0);
        check("ended_sticky", 32'(test_has_ended), 1);

        // Overflow: 15 slots with no consumer, fifth word dropped.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) send(10'(i + 1));
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_drops", 32'(drop_count), 1);
        check("ovf_dct_count", 32'(dct_count), 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovf_pop%0d_valid", k), 32'(out_valid), 1);
            check($sformatf("ovf_pop%0d_data", k), 32'(out_data), word3(3*k+1, 3*k+2, 3*k+3));
            step();
        end
        check("ovf_drained", 32'(out_valid), 0);

        // Full FIFO with a simultaneous pop accepts the new word.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) send(10'(i + 1));
        send(10'h0A1); send(10'h0A2);
        out_ready = 1'b1;
        send(10'h0A3);
        check("fullpop_no_ovf", 32'(overflow), 0);
        check("fullpop_no_drop", 32'(drop_count), 0);
        for (int k = 1; k < 4; k++) begin
            check($sformatf("fullpop_w%0d", k), 32'(out_data), word3(3*k+1, 3*k+2, 3*k+3));
            step();
        end
        check("fullpop_last_valid", 32'(out_valid), 1);
        check("fullpop_last", 32'(out_data), word3('h0A1, 'h0A2, 'h0A3));
        step();
        check("fullpop_empty", 32'(out_valid), 0);

        // Reset while draining two queued words.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(10'(i + 1));
        test_ending = 1'b1; step(); test_ending = 1'b0;
        step(); step();
        check("drain_hold_valid", 32'(out_valid), 1);
        check("drain_hold_in_ready", 32'(in_ready), 0);
        check("drain_hold_ended", 32'(test_has_ended), 0);
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_ended", 32'(test_has_ended), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        reset = 1'b0;
        out_ready = 1'b1;
        send(10'h007); send(10'h008); send(10'h009);
        check("resume_data", 32'(out_data), word3(7, 8, 9));
        check("resume_count", 32'(out_count), 3);

        // test_ending with nothing pending.
        do_reset();
        test_ending = 1'b1; step(); test_ending = 1'b0;
        check("empty_flush_ended", 32'(test_has_ended), 0);
        step();
        check("empty_flush_nopush", 32'(out_valid), 0);
        step();
        check("empty_ended", 32'(test_has_ended), 1);

        // Drop counter saturation: 4 words held, 17 dropped.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 63; i++) send(10'(i));
        check("sat_drop_count", 32'(drop_count), 32'hF);
        check("sat_overflow", 32'(overflow), 1);
        check("sat_held", 32'(out_data), word3(0, 1, 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
